ddr_burst_arbiter: RTL

DDR_BURST_ARBITER -- requirements
Module: ddr_burst_arbiter

---
 rtl/ddr_arb_pkg.sv | 38 +++
 rtl/ddr_arb_picker.sv | 28 ++
 rtl/ddr_burst_arbiter.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types for the DDR burst arbiter.
// States, owner codes, requester indices and default widths.
package ddr_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_LEN_W  = 10;

  typedef enum logic [2:0] {
    ST_CALIB,
    ST_IDLE,
    ST_RD_ISA,
    ST_RD_DATA,
    ST_WR_DATA
  } arb_st_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_ISA  = 2'b01,
    OWN_DRD  = 2'b10,
    OWN_DWR  = 2'b11
  } owner_e;

  localparam logic [1:0] REQ_ISA = 2'd0;
  localparam logic [1:0] REQ_DRD = 2'd1;
  localparam logic [1:0] REQ_DWR = 2'd2;

  // (a + b) mod 3 for requester indices
  function automatic logic [1:0] wrap3(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/ddr_arb_picker.sv
// ddr_arb_picker: combinational 3-way requester picker.
// Highest priority is the requester at index ptr, then ptr+1, ptr+2.
module ddr_arb_picker
  import ddr_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       vld,
  output logic [1:0] idx
);

  logic [1:0] j;

  // scan lowest priority first so the last hit wins
  always_comb begin
    vld = 1'b0;
    idx = REQ_ISA;
    j   = REQ_ISA;
    for (int k = 2; k >= 0; k--) begin
      j = wrap3(ptr, 2'(k));
      if (req[j]) begin
        vld = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: grants one of ISA-rd, DATA-rd, DATA-wr to ddr_controller.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module ddr_burst_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int DDR_ADDR_WIDTH  = DEF_ADDR_W,
  parameter int BURST_LEN_WIDTH = DEF_LEN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       init_calib_complete,
  input  logic                       isa_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  isa_rd_addr,
  input  logic [BURST_LEN_WIDTH-1:0] isa_rd_len,
  input  logic                       data_rd_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  data_rd_addr,
  input  logic [BURST_LEN_WIDTH-1:0] data_rd_len,
  input  logic                       data_wr_req,
  input  logic [DDR_ADDR_WIDTH-1:0]  data_wr_addr,
  input  logic [BURST_LEN_WIDTH-1:0] data_wr_len,
  output logic                       isa_rd_done,
  output logic                       data_rd_done,
  output logic                       data_wr_done,
  output logic                       isa_rd_valid,
  output logic                       data_rd_valid,
  output logic                       data_wr_data_req,
  output logic                       rd_burst_req,
  output logic                       wr_burst_req,
  output logic [DDR_ADDR_WIDTH-1:0]  rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]  wr_burst_addr,
  output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  output logic [BURST_LEN_WIDTH-1:0] wr_burst_len,
  input  logic                       rd_burst_finish,
  input  logic                       wr_burst_finish,
  input  logic                       rd_burst_data_valid,
  input  logic                       wr_burst_data_req,
  output logic [1:0]                 owner,
  output logic                       busy,
  output logic                       proto_err
);

  localparam int AW = DDR_ADDR_WIDTH;
  localparam int LW = BURST_LEN_WIDTH;

  arb_st_e       st_q, st_d;
  logic [AW-1:0] addr_q, addr_d, sel_addr;
  logic [LW-1:0] len_q, len_d, sel_len;
  logic          rd_req_q, rd_req_d;
  logic          wr_req_q, wr_req_d;
  logic [2:0]    done_q, done_d;
  logic          err_q, err_d;
  logic [1:0]    ptr, pick_idx;
  logic          pick_vld, take;
  logic          rd_fin, wr_fin;

  ddr_arb_picker u_picker (
    .req ({data_wr_req, data_rd_req, isa_rd_req}),
    .ptr (ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  // no arbitration in the done cycle: the finished requester's
  // req is still high there and must not look like a new request
  assign take = (st_q == ST_IDLE) & init_calib_complete
              & pick_vld & ~|done_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    ptr_q <= REQ_ISA;
    else if (take) ptr_q <= wrap3(pick_idx, 2'd1);
  end

  assign ptr = ptr_q;
`else
  assign ptr = REQ_ISA;
`endif

  assign rd_fin = rd_burst_finish & rd_req_q;
  assign wr_fin = wr_burst_finish & wr_req_q;

  always_comb begin
    sel_addr = data_wr_addr;
    sel_len  = data_wr_len;
    unique case (pick_idx)
      REQ_ISA: begin
        sel_addr = isa_rd_addr;
        sel_len  = isa_rd_len;
      end
      REQ_DRD: begin
        sel_addr = data_rd_addr;
        sel_len  = data_rd_len;
      end
      default: ;
    endcase
  end

  always_comb begin
    st_d     = st_q;
    addr_d   = addr_q;
    len_d    = len_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    done_d   = 3'b000;
    err_d    = err_q
             | (rd_burst_finish & ~rd_req_q)
             | (wr_burst_finish & ~wr_req_q);
    unique case (st_q)
      ST_CALIB: begin
        if (init_calib_complete) st_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (!init_calib_complete) begin
          st_d = ST_CALIB;
        end else if (take) begin
          addr_d   = sel_addr;
          len_d    = sel_len;
          rd_req_d = (pick_idx != REQ_DWR) && (sel_len != '0);
          wr_req_d = (pick_idx == REQ_DWR) && (sel_len != '0);
          unique case (pick_idx)
            REQ_ISA: st_d = ST_RD_ISA;
            REQ_DRD: st_d = ST_RD_DATA;
            default: st_d = ST_WR_DATA;
          endcase
        end
      end
      ST_RD_ISA, ST_RD_DATA: begin
        if ((len_q == '0) || rd_fin) begin
          rd_req_d = 1'b0;
          st_d     = ST_IDLE;
          done_d   = (st_q == ST_RD_ISA) ? 3'b001 : 3'b010;
        end
      end
      ST_WR_DATA: begin
        if ((len_q == '0) || wr_fin) begin
          wr_req_d = 1'b0;
          st_d     = ST_IDLE;
          done_d   = 3'b100;
        end
      end
      default: st_d = ST_CALIB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_CALIB;
      addr_q   <= '0;
      len_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      done_q   <= 3'b000;
      err_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    owner = OWN_NONE;
    unique case (st_q)
      ST_RD_ISA:  owner = OWN_ISA;
      ST_RD_DATA: owner = OWN_DRD;
      ST_WR_DATA: owner = OWN_DWR;
      default:    owner = OWN_NONE;
    endcase
  end

  assign busy = (st_q == ST_RD_ISA)
              | (st_q == ST_RD_DATA)
              | (st_q == ST_WR_DATA);

  assign isa_rd_valid     = rd_burst_data_valid
                          & (st_q == ST_RD_ISA);
  assign data_rd_valid    = rd_burst_data_valid
                          & (st_q == ST_RD_DATA);
  assign data_wr_data_req = wr_burst_data_req
                          & (st_q == ST_WR_DATA);

  assign rd_burst_req  = rd_req_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_addr = addr_q;
  assign wr_burst_addr = addr_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_len  = len_q;

  assign isa_rd_done  = done_q[0];
  assign data_rd_done = done_q[1];
  assign data_wr_done = done_q[2];
  assign proto_err    = err_q;

endmodule
